// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use detection, multi-cycle multiply freeze,
// data-memory wait states and taken-branch flushes, with saturating stall/flush counters.
module hazard_ctrl_unit #(
    parameter int unsigned REG_AW        = 5,
    parameter int unsigned LOAD_USE_DIST = 1,
    parameter int unsigned MUL_LAT       = 4,
    parameter int unsigned CNT_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              idex_write,
    input  logic              idex_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_write,
    input  logic              exmem_memread,
    input  logic              ex_mul_start,
    input  logic              branch_taken,
    input  logic              mem_busy,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_hold,
    output logic              exmem_bubble,
    output logic              exmem_hold,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam int unsigned MW       = (MUL_LAT > 1) ? $clog2(MUL_LAT + 1) : 1;
    localparam int unsigned MUL_INIT = (MUL_LAT > 2) ? MUL_LAT - 2 : 0;
    localparam logic        MUL_MULTI = (MUL_LAT > 1);
    localparam logic        MUL_LONG  = (MUL_LAT > 2);
    localparam logic        DIST2     = (LOAD_USE_DIST == 2);

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MUL_BUSY = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [MW-1:0]    mcnt_q, mcnt_d;
    logic             ret_mul_q, ret_mul_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             flush_inc;
    logic             idex_hit, exmem_hit, load_use;

    // r0 is never a real producer, so it is masked per operand
    always_comb begin
        idex_hit  = (idex_rd != '0) &&
                    ((id_uses_rs && id_rs == idex_rd) || (id_uses_rt && id_rt == idex_rd));
        exmem_hit = (exmem_rd != '0) &&
                    ((id_uses_rs && id_rs == exmem_rd) || (id_uses_rt && id_rt == exmem_rd));
        load_use  = (idex_write && idex_memread && idex_hit) ||
                    (DIST2 && exmem_write && exmem_memread && exmem_hit);
    end

    // Next state and pipeline controls; priority mem_busy > MUL_BUSY > branch > mul start > load-use
    always_comb begin
        state_d      = state_q;
        mcnt_d       = mcnt_q;
        ret_mul_d    = ret_mul_q;
        flush_inc    = 1'b0;
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        exmem_hold   = 1'b0;
        if (reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (mem_busy) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
            state_d    = ST_MEM_WAIT;
            if (state_q != ST_MEM_WAIT) begin
                ret_mul_d = (state_q == ST_MUL_BUSY);
            end
        end else begin
            case (state_q)
                ST_MEM_WAIT: begin
                    state_d = ret_mul_q ? ST_MUL_BUSY : ST_RUN;
                end
                ST_MUL_BUSY: begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_hold    = 1'b1;
                    exmem_bubble = 1'b1;
                    mcnt_d       = mcnt_q - MW'(1);
                    if (mcnt_q <= MW'(1)) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    if (branch_taken) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (ex_mul_start && MUL_MULTI) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        idex_hold    = 1'b1;
                        exmem_bubble = 1'b1;
                        mcnt_d       = MW'(MUL_INIT);
                        state_d      = MUL_LONG ? ST_MUL_BUSY : ST_RUN;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RUN;
            mcnt_q      <= '0;
            ret_mul_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mcnt_q    <= mcnt_d;
            ret_mul_q <= ret_mul_d;
            if (!pc_write && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (flush_inc && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench: default unit (DIST=1, MUL_LAT=4) and a DIST=2, MUL_LAT=2, 2-bit-counter unit
// driven from the same pipeline inputs.
module tb_hazard_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, idex_rd, exmem_rd;
    logic       id_uses_rs, id_uses_rt, idex_write, idex_memread;
    logic       exmem_write, exmem_memread, ex_mul_start, branch_taken, mem_busy;

    logic        pc_write, ifid_write, ifid_flush, idex_bubble, idex_hold, exmem_bubble, exmem_hold;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_write2, ifid_write2, ifid_flush2, idex_bubble2, idex_hold2, exmem_bubble2, exmem_hold2;
    logic [1:0]  stall_cnt2, flush_cnt2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit dut (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .idex_rd(idex_rd), .idex_write(idex_write), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_write(exmem_write), .exmem_memread(exmem_memread),
        .ex_mul_start(ex_mul_start), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .idex_hold(idex_hold),
        .exmem_bubble(exmem_bubble), .exmem_hold(exmem_hold),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl_unit #(.REG_AW(5), .LOAD_USE_DIST(2), .MUL_LAT(2), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .idex_rd(idex_rd), .idex_write(idex_write), .idex_memread(idex_memread),
        .exmem_rd(exmem_rd), .exmem_write(exmem_write), .exmem_memread(exmem_memread),
        .ex_mul_start(ex_mul_start), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_write(pc_write2), .ifid_write(ifid_write2), .ifid_flush(ifid_flush2),
        .idex_bubble(idex_bubble2), .idex_hold(idex_hold2),
        .exmem_bubble(exmem_bubble2), .exmem_hold(exmem_hold2),
        .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_rs = '0; id_rt = '0; idex_rd = '0; exmem_rd = '0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; idex_write = 1'b0; idex_memread = 1'b0;
        exmem_write = 1'b0; exmem_memread = 1'b0;
        ex_mul_start = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic set_idex_load_use();
        idex_memread = 1'b1; idex_write = 1'b1; idex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    endtask

    task automatic check_freeze(input string tag);
        check({tag, " pc_write"}, 32'(pc_write), 0);
        check({tag, " idex_hold"}, 32'(idex_hold), 1);
        check({tag, " exmem_bubble"}, 32'(exmem_bubble), 1);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        #1;
        check("rst pc_write", 32'(pc_write), 0);
        check("rst ifid_write", 32'(ifid_write), 0);
        check("rst ifid_flush", 32'(ifid_flush), 1);
        check("rst idex_bubble", 32'(idex_bubble), 1);
        check("rst exmem_hold", 32'(exmem_hold), 0);
        step();
        reset = 1'b0;
        #1;
        check("idle pc_write", 32'(pc_write), 1);
        check("idle stall_cnt", 32'(stall_cnt), 0);
        check("idle flush_cnt", 32'(flush_cnt), 0);

        // T1: load-use against ID/EX
        set_idex_load_use();
        #1;
        check("t1 pc_write", 32'(pc_write), 0);
        check("t1 ifid_write", 32'(ifid_write), 0);
        check("t1 idex_bubble", 32'(idex_bubble), 1);
        check("t1 d2 pc_write", 32'(pc_write2), 0);
        step();
        clear_inputs();
        #1;
        check("t1 stall_cnt", 32'(stall_cnt), 1);
        check("t1 released", 32'(pc_write), 1);

        // T2: r0 and unused operand are not hazards
        idex_memread = 1'b1; idex_write = 1'b1; idex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        #1;
        check("t2 r0 pc_write", 32'(pc_write), 1);
        idex_rd = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b0;
        #1;
        check("t2 unused pc_write", 32'(pc_write), 1);
        check("t2 unused bubble", 32'(idex_bubble), 0);
        step();
        clear_inputs();
        #1;
        check("t2 stall_cnt", 32'(stall_cnt), 1);

        // T3: EX/MEM load hazard only seen at distance 2
        exmem_memread = 1'b1; exmem_write = 1'b1; exmem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
        #1;
        check("t3 dist1 pc_write", 32'(pc_write), 1);
        check("t3 dist2 pc_write", 32'(pc_write2), 0);
        check("t3 dist2 bubble", 32'(idex_bubble2), 1);
        step();
        clear_inputs();
        #1;
        check("t3 d2 stall_cnt", 32'(stall_cnt2), 2);

        // T4: multiply freeze, 3 cycles at MUL_LAT=4, 1 cycle at MUL_LAT=2
        ex_mul_start = 1'b1;
        #1;
        check_freeze("t4 c0");
        check("t4 c0 d2 pc_write", 32'(pc_write2), 0);
        step();
        ex_mul_start = 1'b0;
        #1;
        check_freeze("t4 c1");
        check("t4 c1 d2 pc_write", 32'(pc_write2), 1);
        step();
        check_freeze("t4 c2");
        step();
        check("t4 done pc_write", 32'(pc_write), 1);
        check("t4 done exmem_bubble", 32'(exmem_bubble), 0);
        check("t4 stall_cnt", 32'(stall_cnt), 4);
        check("t4 d2 stall_cnt", 32'(stall_cnt2), 3);

        // T5: memory wait during the second MUL_BUSY cycle
        ex_mul_start = 1'b1;
        #1;
        check_freeze("t5 a");
        step();
        ex_mul_start = 1'b0;
        #1;
        check_freeze("t5 b");
        step();
        check_freeze("t5 c");
        mem_busy = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("t5 wait exmem_hold", 32'(exmem_hold), 1);
            check("t5 wait exmem_bubble", 32'(exmem_bubble), 0);
            check("t5 wait pc_write", 32'(pc_write), 0);
            step();
        end
        mem_busy = 1'b0;
        #1;
        check("t5 exit pc_write", 32'(pc_write), 1);
        check("t5 exit exmem_hold", 32'(exmem_hold), 0);
        step();
        check_freeze("t5 resume");
        step();
        check("t5 done pc_write", 32'(pc_write), 1);
        check("t5 stall_cnt", 32'(stall_cnt), 10);
        check("t5 d2 stall_sat", 32'(stall_cnt2), 3);

        // T6: branch wins over load-use
        set_idex_load_use();
        branch_taken = 1'b1;
        #1;
        check("t6 ifid_flush", 32'(ifid_flush), 1);
        check("t6 idex_bubble", 32'(idex_bubble), 1);
        check("t6 pc_write", 32'(pc_write), 1);
        step();
        clear_inputs();
        #1;
        check("t6 flush_cnt", 32'(flush_cnt), 1);
        check("t6 stall_cnt", 32'(stall_cnt), 10);

        // Reset while in MUL_BUSY aborts to RUN
        ex_mul_start = 1'b1;
        step();
        ex_mul_start = 1'b0;
        reset = 1'b1;
        #1;
        check("t6 rst ifid_flush", 32'(ifid_flush), 1);
        check("t6 rst exmem_bubble", 32'(exmem_bubble), 0);
        step();
        reset = 1'b0;
        #1;
        check("t6 post pc_write", 32'(pc_write), 1);
        check("t6 post stall_cnt", 32'(stall_cnt), 0);
        check("t6 post flush_cnt", 32'(flush_cnt), 0);
        step();
        check("t6 post2 pc_write", 32'(pc_write), 1);
        check("t6 post2 stall_cnt", 32'(stall_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
